// File: rtl/maxpool1d_stage.sv
// maxpool1d_stage: non-overlapping 1-D signed max-pool with ready/valid on both sides.
// Define MAXPOOL_FLUSH_EN to add in_last, which closes a partial window at end of row.

package params_pkg;
    localparam int DATA_WIDTH = 16;
endpackage

module maxpool1d_stage #(
    parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter int POOL_SIZE  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
`ifdef MAXPOOL_FLUSH_EN
    input  logic                         in_last,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data
);

    localparam int CW = $clog2(POOL_SIZE);

    // Window phase is derived from the beat counter; the counter is the state.
    typedef enum logic {
        S_FIRST,
        S_ACCUM
    } phase_e;

    logic [CW-1:0]                r_win_cnt;
    logic signed [DATA_WIDTH-1:0] r_run_max;
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic                         r_out_valid;

    phase_e                       w_phase;
    logic                         w_cnt_close;
    logic                         w_last_req;
    logic                         w_close;
    logic                         w_accept;
    logic                         w_consume;
    logic signed [DATA_WIDTH-1:0] w_max;

    // Decode phase and whether the offered beat closes a window.
    always_comb begin
        w_phase     = (r_win_cnt == '0) ? S_FIRST : S_ACCUM;
        w_cnt_close = (r_win_cnt == CW'(POOL_SIZE - 1));
`ifdef MAXPOOL_FLUSH_EN
        w_last_req  = in_valid & in_last;
`else
        w_last_req  = 1'b0;
`endif
        w_close     = w_cnt_close | w_last_req;
    end

    // Only a closing beat needs room in the output register.
    always_comb begin
        in_ready  = ~w_close | ~r_out_valid | out_ready;
        w_accept  = in_valid & in_ready;
        w_consume = r_out_valid & out_ready;
    end

    // Running maximum including the current beat; a new window drops the old max.
    always_comb begin
        w_max = in_data;
        unique case (w_phase)
            S_FIRST: w_max = in_data;
            S_ACCUM: w_max = (in_data > r_run_max) ? in_data : r_run_max;
            default: w_max = in_data;
        endcase
    end

    // Window counter and partial maximum advance only on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
            r_run_max <= '0;
        end else if (w_accept) begin
            r_run_max <= w_max;
            if (w_close) begin
                r_win_cnt <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + CW'(1);
            end
        end
    end

    // Single-entry output register; a close reloads it even while being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept && w_close) begin
            r_out_data  <= w_max;
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_maxpool1d_stage.sv
// tb_maxpool1d_stage: directed plus random ready/valid traffic against a
// queue-based window model; POOL_SIZE=4.
module tb_maxpool1d_stage;

    localparam int DW = 16;
    localparam int PS = 4;
`ifdef MAXPOOL_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
`ifdef MAXPOOL_FLUSH_EN
    logic                 in_last;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;

    int total = 0;
    int bad   = 0;
    int win_q[$];
    int exp_q[$];
    int got_q[$];

    always #5 clk = ~clk;

    maxpool1d_stage #(
        .DATA_WIDTH(DW),
        .POOL_SIZE (PS)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
`ifdef MAXPOOL_FLUSH_EN
        .in_last  (in_last),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int win_max();
        int m;
        m = win_q[0];
        foreach (win_q[i]) if (win_q[i] > m) m = win_q[i];
        return m;
    endfunction

    // One clock: drive after the edge, check and update the model at negedge.
    task automatic step(input bit v, input int d, input bit r, input bit l);
        bit close_next;
        bit exp_rdy;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = DW'(d);
        out_ready = r;
`ifdef MAXPOOL_FLUSH_EN
        in_last   = l;
`endif
        @(negedge clk);
        chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
        if (out_valid && exp_q.size() != 0)
            chk("out_data", int'(out_data), exp_q[0]);
        close_next = (win_q.size() == PS - 1) || (FLUSH && v && l);
        exp_rdy    = !close_next || (exp_q.size() == 0) || r;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        if (out_valid && r) begin
            got_q.push_back(int'(out_data));
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (v && in_ready) begin
            win_q.push_back(int'(in_data));
            if (win_q.size() == PS || (FLUSH && l)) begin
                exp_q.push_back(win_max());
                win_q.delete();
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_data", int'(out_data), 0);
        win_q.delete();
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        int d;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef MAXPOOL_FLUSH_EN
        in_last   = 1'b0;
`endif
        #1;
        chk("init_out_valid", int'(out_valid), 0);
        chk("init_in_ready", int'(in_ready), 1);
        chk("init_out_data", int'(out_data), 0);
        #11;
        rst_n = 1'b1;

        // basic windows
        got_q.delete();
        step(1, 3, 1, 0); step(1, 7, 1, 0); step(1, 5, 1, 0); step(1, 2, 1, 0);
        step(1, 4, 1, 0); step(1, 1, 1, 0); step(1, 9, 1, 0); step(1, 9, 1, 0);
        drain();
        chk("t1_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t1_out0", got_q[0], 7);
            chk("t1_out1", got_q[1], 9);
        end

        // signed compare
        got_q.delete();
        step(1, -5, 1, 0); step(1, -3, 1, 0); step(1, -128, 1, 0); step(1, -1000, 1, 0);
        step(1, -128, 1, 0); step(1, -1000, 1, 0); step(1, -200, 1, 0); step(1, -129, 1, 0);
        drain();
        chk("t2_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t2_out0", got_q[0], -3);
            chk("t2_out1", got_q[1], -128);
        end

        // backpressure on the closing beat only
        got_q.delete();
        step(1, 3, 1, 0); step(1, 7, 1, 0); step(1, 5, 1, 0); step(1, 2, 0, 0);
        step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
        chk("t3_close_blocked", int'(in_ready), 0);
        step(1, 4, 0, 0);
        chk("t3_hold", int'(out_data), 7);
        step(1, 4, 1, 0);
        drain();
        chk("t3_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t3_out0", got_q[0], 7);
            chk("t3_out1", got_q[1], 4);
        end

        // streaming 1..8
        got_q.delete();
        for (int i = 1; i <= 8; i++) begin
            step(1, i, 1, 0);
            chk("t4_ready", int'(in_ready), 1);
        end
        drain();
        chk("t4_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t4_out0", got_q[0], 4);
            chk("t4_out1", got_q[1], 8);
        end

        // reset mid-window discards partial max
        step(1, 9, 1, 0); step(1, 9, 1, 0); step(0, 0, 1, 0);
        do_reset();
        got_q.delete();
        step(1, 1, 1, 0); step(1, 2, 1, 0); step(1, 3, 1, 0); step(1, 4, 1, 0);
        drain();
        chk("t5_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("t5_out", got_q[0], 4);

`ifdef MAXPOOL_FLUSH_EN
        // flush partial window on in_last
        got_q.delete();
        step(1, 6, 1, 0); step(1, 2, 1, 1);
        step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 3, 1, 0); step(1, 2, 1, 0);
        drain();
        chk("t6_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t6_out0", got_q[0], 6);
            chk("t6_out1", got_q[1], 3);
        end
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                d = int'($urandom_range(0, 65535)) - 32768;
                step($urandom_range(0, 3) != 0, d,
                     $urandom_range(0, 2) != 0,
                     $urandom_range(0, 5) == 0);
            end
        end
        drain();
        chk("final_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
